// File: rtl/ristretto_imem_arbiter.sv
// ristretto_imem_arbiter: round-robin sharing of one imem port between fetch (port 0) and a secondary master (port 1)
// One outstanding transaction; a watchdog aborts transactions whose response never arrives.
module ristretto_imem_arbiter #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [1:0]                rq_req_i,
    input  logic [1:0][AddrWidth-1:0] rq_addr_i,
    output logic [1:0]                rq_ready_o,
    output logic [1:0]                rq_valid_o,
    output logic [DataWidth-1:0]      rq_rdata_o,
    output logic                      mem_req_o,
    output logic [AddrWidth-1:0]      mem_addr_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_valid_i,
    input  logic [DataWidth-1:0]      mem_rdata_i,
    output logic [1:0]                grant_o,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int WdW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_WRDY, ARB_WVLD} state_t;

    state_t               state, state_nx;
    logic                 ptr, ptr_nx, win, done;
    logic [1:0]           grant_nx;
    logic [AddrWidth-1:0] addr_nx;
    logic [WdW-1:0]       wdog, wdog_nx;

    assign rq_rdata_o = mem_rdata_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ARB_IDLE;
            grant_o    <= '0;
            ptr        <= 1'b0;
            mem_addr_o <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_nx;
            grant_o    <= grant_nx;
            ptr        <= ptr_nx;
            mem_addr_o <= addr_nx;
            wdog       <= wdog_nx;
        end
    end

    always_comb begin
        win        = (rq_req_i == 2'b11) ? ptr : rq_req_i[1];
        state_nx   = state;
        grant_nx   = grant_o;
        ptr_nx     = ptr;
        addr_nx    = mem_addr_o;
        wdog_nx    = wdog;
        rq_ready_o = '0;
        rq_valid_o = '0;
        timeout_o  = 1'b0;
        done       = 1'b0;
        mem_req_o  = state == ARB_WRDY;
        busy_o     = state != ARB_IDLE;
        case (state)
            ARB_IDLE: if (|rq_req_i) begin
                state_nx = ARB_WRDY;
                grant_nx = win ? 2'b10 : 2'b01;
                addr_nx  = rq_addr_i[win];
            end
            ARB_WRDY: if (mem_ready_i) begin
                rq_ready_o = grant_o;
                state_nx   = ARB_WVLD;
                wdog_nx    = '0;
            end
            ARB_WVLD: begin
                // wdog counts completed wait cycles, so the abort lands on wait cycle TimeoutCycles
                if (mem_valid_i) begin
                    rq_valid_o = grant_o;
                    done       = 1'b1;
                end else if (TimeoutCycles != 0 && wdog == WdLast) begin
                    timeout_o = 1'b1;
                    done      = 1'b1;
                end else if (TimeoutCycles != 0) begin
                    wdog_nx = wdog + 1'b1;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
        if (done) begin
            state_nx = ARB_IDLE;
            grant_nx = '0;
            ptr_nx   = ~grant_o[1];
        end
    end
endmodule
